// File: rtl/mips_pkg.sv
// mips_pkg: operation classes, opcodes and loader states shared by the encoder and control decoder.
package mips_pkg;
  typedef enum logic [3:0] {
    OP_R = 4'd0, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J = 4'd8
  } instr_op_e;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  typedef enum logic [1:0] {IDLE, RUN, FULL} enc_state_e;
endpackage

// File: rtl/mips_instr_pack.sv
// mips_instr_pack: combinational packer from operation class and fields to a 32-bit MIPS word.
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);
  logic [5:0] opc;
  always_comb begin
    opc = OPC_RTYPE;
    legal = 1'b1;
    case (op)
      OP_R:    opc = OPC_RTYPE;
      OP_LW:   opc = OPC_LW;
      OP_SW:   opc = OPC_SW;
      OP_BEQ:  opc = OPC_BEQ;
      OP_BNE:  opc = OPC_BNE;
      OP_ADDI: opc = OPC_ADDI;
      OP_ANDI: opc = OPC_ANDI;
      OP_ORI:  opc = OPC_ORI;
      OP_J:    opc = OPC_J;
      default: legal = 1'b0;
    endcase
    word = op == OP_J ? {opc, target} :
           op == OP_R ? {opc, rs, rt, rd, shamt, funct} : {opc, rs, rt, imm};
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: accepts symbolic instruction requests and writes encoded words sequentially into instruction memory.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);
  enc_state_e state, state_next;
  logic [31:0] word;
  logic legal, xfer;
  logic [ADDR_W:0] count_next;
  mips_instr_pack u_pack (
    .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd), .shamt(in_shamt),
    .funct(in_funct), .imm(in_imm), .target(in_target), .word(word), .legal(legal)
  );
  // mem_we doubles as the pending flag: a registered word not yet counted
  assign count_next = count + (ADDR_W+1)'(mem_we);
  assign in_ready = state == RUN && count_next < (ADDR_W+1)'(DEPTH);
  assign xfer = in_valid && in_ready && !start;
  assign full = state == FULL;
  always_comb
    state_next = start ? RUN :
                 state == RUN && stop ? IDLE :
                 state == RUN && count_next == (ADDR_W+1)'(DEPTH) ? FULL : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_we <= 1'b0;
      mem_addr <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      count <= '0;
      err_illegal <= 1'b0;
    end else if (start) begin
      mem_we <= 1'b0;
      mem_addr <= ADDR_W'(BASE_ADDR);
      count <= '0;
      err_illegal <= 1'b0;
    end else begin
      mem_we <= xfer && legal;
      count <= count_next;
      if (xfer && legal) begin
        mem_addr <= ADDR_W'(BASE_ADDR) + count_next[ADDR_W-1:0];
        mem_wdata <= word;
      end
      if (xfer && !legal) err_illegal <= 1'b1;
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed checks of encoding, handshake, full boundary, start/stop and reset behaviour.
module tb_mips_instr_encoder;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [3:0] in_op = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0] in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic b_ready, b_we, b_full, b_err, s_ready, s_we, s_full, s_err;
  logic [7:0] b_addr, s_addr;
  logic [31:0] b_wdata, s_wdata;
  logic [8:0] b_count, s_count;
  int checks = 0, failures = 0, small_writes = 0, base_writes;
  always #5 clk = ~clk;
  mips_instr_encoder u_big (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(b_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .count(b_count), .full(b_full), .err_illegal(b_err)
  );
  mips_instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(16)) u_small (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(s_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .mem_we(s_we),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .count(s_count), .full(s_full), .err_illegal(s_err)
  );
  always @(posedge clk) if (s_we) small_writes <= small_writes + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req_r(input logic [4:0] rs, rt, rd, shamt, input logic [5:0] funct);
    in_valid = 1'b1; in_op = 4'd0; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
    in_funct = funct; in_imm = 16'($urandom); in_target = 26'($urandom);
  endtask
  task automatic req_i(input logic [3:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_imm = imm;
    in_rd = 5'($urandom); in_shamt = 5'($urandom); in_funct = 6'($urandom); in_target = 26'($urandom);
  endtask
  task automatic req_j(input logic [25:0] target);
    in_valid = 1'b1; in_op = 4'd8; in_target = target;
    in_rs = 5'($urandom); in_rt = 5'($urandom); in_imm = 16'($urandom);
  endtask
  initial begin
    tick(); tick();
    chk("rst_ready", b_ready, 0); chk("rst_we", b_we, 0); chk("rst_addr", b_addr, 0);
    chk("rst_wdata", b_wdata, 0); chk("rst_count", b_count, 0); chk("rst_full", b_full, 0);
    chk("rst_err", b_err, 0); chk("rst_small_addr", s_addr, 16);
    reset = 1'b0; tick();
    chk("idle_ready", b_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("run_ready", b_ready, 1);
    req_r(1, 2, 3, 0, 6'h20); tick(); in_valid = 1'b0;
    chk("r_we", b_we, 1); chk("r_addr", b_addr, 0); chk("r_wdata", b_wdata, 32'h00221820);
    chk("r_count_pre", b_count, 0);
    tick();
    chk("r_we_drop", b_we, 0); chk("r_count", b_count, 1); chk("r_wdata_hold", b_wdata, 32'h00221820);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_count", b_count, 0);
    req_i(4'd1, 29, 8, 16'h0004); tick();
    req_i(4'd4, 8, 0, 16'hFFFE);
    chk("lw_we", b_we, 1); chk("lw_addr", b_addr, 0); chk("lw_wdata", b_wdata, 32'h8FA80004);
    tick();
    req_j(26'h0000010);
    chk("bne_we", b_we, 1); chk("bne_addr", b_addr, 1); chk("bne_wdata", b_wdata, 32'h1500FFFE);
    tick(); in_valid = 1'b0;
    chk("j_we", b_we, 1); chk("j_addr", b_addr, 2); chk("j_wdata", b_wdata, 32'h08000010);
    tick();
    chk("b2b_we_drop", b_we, 0); chk("b2b_count", b_count, 3);
    in_valid = 1'b1; in_op = 4'hF; tick(); in_valid = 1'b0;
    chk("ill_we", b_we, 0); chk("ill_err", b_err, 1); chk("ill_count", b_count, 3);
    tick();
    chk("ill_err_sticky", b_err, 1);
    req_i(4'd5, 0, 9, 16'd5); tick(); in_valid = 1'b0;
    chk("addi_we", b_we, 1); chk("addi_addr", b_addr, 3); chk("addi_wdata", b_wdata, 32'h20090005);
    tick();
    chk("addi_count", b_count, 4); chk("addi_err_sticky", b_err, 1);
    start = 1'b1; tick(); start = 1'b0;
    base_writes = small_writes;
    chk("full_ready0", s_ready, 1); chk("full_clr", s_full, 0);
    req_i(4'd2, 29, 31, 16'h0008); tick();
    chk("sw_we", s_we, 1); chk("sw_addr", s_addr, 8'h10); chk("sw_wdata", s_wdata, 32'hAFBF0008);
    chk("full_ready1", s_ready, 1);
    tick(); tick(); tick();
    chk("full_ready4", s_ready, 0); chk("full_we4", s_we, 1); chk("full_addr4", s_addr, 8'h13);
    chk("full_pre", s_full, 0);
    tick();
    chk("full_set", s_full, 1); chk("full_we_drop", s_we, 0); chk("full_count", s_count, 4);
    tick(); in_valid = 1'b0;
    chk("full_ready_hold", s_ready, 0); chk("full_no_5th", s_we, 0);
    chk("full_writes", small_writes - base_writes, 4);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_op = 4'hF; tick();
    req_i(4'd7, 2, 3, 16'h00FF); tick(); in_valid = 1'b0;
    chk("ori_err", b_err, 1); chk("ori_wdata", b_wdata, 32'h344300FF);
    start = 1'b1; tick(); start = 1'b0;
    chk("cancel_we", b_we, 0); chk("cancel_count", b_count, 0); chk("cancel_err", b_err, 0);
    chk("cancel_full", s_full, 0); chk("cancel_ready", b_ready, 1); chk("cancel_small_count", s_count, 0);
    start = 1'b1; req_j(26'h0000123); tick(); start = 1'b0; in_valid = 1'b0;
    chk("start_discard", b_we, 0);
    req_r(1, 2, 3, 0, 6'h20); tick(); in_valid = 1'b0;
    chk("post_start_addr", b_addr, 0); chk("post_start_we", b_we, 1);
    tick();
    req_i(4'd1, 29, 8, 16'h0004); tick(); in_valid = 1'b0; stop = 1'b1;
    chk("stop_we", b_we, 1); chk("stop_addr", b_addr, 1);
    tick(); stop = 1'b0;
    chk("stop_ready", b_ready, 0); chk("stop_count", b_count, 2); chk("stop_we_drop", b_we, 0);
    start = 1'b1; tick(); start = 1'b0;
    req_i(4'd3, 1, 2, 16'd3); tick(); tick();
    chk("mid_we", b_we, 1); chk("mid_count", b_count, 1);
    #2 reset = 1'b1; #1;
    chk("async_we", b_we, 0); chk("async_ready", b_ready, 0); chk("async_count", b_count, 0);
    chk("async_small_count", s_count, 0);
    in_valid = 1'b0; tick(); reset = 1'b0; tick();
    chk("post_reset_idle", b_ready, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the main control decoder. It takes symbolic instruction requests (operation class plus register, immediate and target fields) over a valid/ready handshake.
- Each request is packed into a 32-bit MIPS word and written sequentially into instruction memory through a write port.
- Serves as the program loader/self-test stimulus path in front of the single-cycle CPU's instruction memory.
- Supports the same instruction set as the CPU: R-type, lw, sw, beq, bne, addi, andi, ori, j.

Parameters:
- ADDR_W, 8, word-address width of the instruction-memory write port.
- DEPTH, 256, number of words the loader may write (must be ≤ 2**ADDR_W).
- BASE_ADDR, 0, word address of the first write after start.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse: clear pointer/count/error, enter RUN.
- stop  input  1  pulse: return to IDLE (pending write still completes).
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- in_op  input  4  operation class (package enum).
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field (R-type only).
- in_shamt  input  5  shamt field (R-type only).
- in_funct  input  6  funct field (R-type only).
- in_imm  input  16  immediate/offset (I-type only).
- in_target  input  26  jump target (J only).
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  encoded instruction word.
- count  output  ADDR_W+1  words written since start.
- full  output  1  DEPTH words written.
- err_illegal  output  1  sticky: an unsupported in_op was accepted.

Behaviour:
- Reset (async): state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err_illegal=0, pending=0.
- States:
  - IDLE: in_ready=0; start -> RUN.
  - RUN: accept requests; stop -> IDLE; count+pending reaching DEPTH -> FULL.
  - FULL: full=1, in_ready=0; only start or reset exits.
- in_ready = (state==RUN) && (count + pending < DEPTH). It depends only on registered state, never on in_valid.
- Handshake: a transfer occurs on a cycle with in_valid && in_ready. Fields are sampled only on a transfer; inputs are don't-care otherwise.
- Latency: a transfer at cycle N gives mem_we=1 in cycle N+1, with mem_wdata the encoded word and mem_addr = BASE_ADDR + count. count increments at the end of N+1. Back-to-back transfers give back-to-back writes at consecutive addresses.
- mem_we is a single-cycle strobe per word; mem_addr/mem_wdata hold their last values when mem_we=0.
- Encoding:
  - R-type: {000000, rs, rt, rd, shamt, funct}.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101: {opcode, rs, rt, imm}.
  - j: {000010, target}.
  - Unused fields are ignored, not checked.
- Illegal in_op (any value outside the enum): transfer still completes (in_ready honoured); err_illegal is set the next cycle; no write; count unchanged.
- Full boundary: accepting the word that makes count+pending==DEPTH drops in_ready the same cycle the transfer is registered. That write completes, then the state becomes FULL with full=1.
- Address never wraps; writes beyond DEPTH are impossible by construction.
- start in any state (including with a write pending): the pending write is cancelled (mem_we=0 next cycle). count=0, mem_addr=BASE_ADDR, err_illegal=0, full=0, state=RUN. start has priority over stop and over a same-cycle transfer, which is discarded.
- stop with a write pending: the write completes; in_ready=0 from the next cycle.
- Reset mid-write: mem_we drops immediately (async); all state cleared.

Decomposition:
- Shared package mips_pkg holds:
  - enum instr_op_e: OP_R=0, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J=8.
  - 6-bit opcode constants (OPC_RTYPE, OPC_LW, ...), shared with the control decoder.
  - enc_state_e {IDLE, RUN, FULL}.
- One natural sub-module, mips_instr_pack: a purely combinational op+fields -> {word, legal} packer, reused by the testbench reference model.

Test Plan:
- Reset then start; send OP_R rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> one cycle later mem_we=1, addr 0, wdata 0x00221820; count=1.
- Back-to-back OP_LW rs=29 rt=8 imm=0x0004, OP_BNE rs=8 rt=0 imm=0xFFFE, OP_J target=0x0000010 -> wdata 0x8FA80004, 0x1500FFFE, 0x08000010 at addresses 0,1,2 on consecutive cycles.
- DEPTH=4, in_valid held high -> exactly 4 writes; in_ready low on the 4th accept cycle; full=1 after; a 5th request is never accepted.
- in_op=0xF accepted -> no mem_we; err_illegal=1 next cycle and stays set; next legal OP_ADDI rs=0 rt=9 imm=5 -> 0x20090005 at the unchanged address.
- start asserted the cycle after an accept -> no write for that word; count=0, err_illegal=0; next word lands at BASE_ADDR.
- reset asserted mid-stream between clock edges -> mem_we, in_ready and count drop to 0 immediately.
